// File: rtl/des_cbc_ctrl_if.sv
// Block stream (in/out) and DES core handshake bundle for the ECB/CBC controller.
interface des_cbc_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        des_start;
  logic [63:0] des_plain;
  logic [63:0] des_key;
  logic [63:0] des_cipher;
  logic        des_valid;

  // slave: the controller; master: block source/sink plus the DES core
  modport slave (
    input  in_valid, in_data, out_ready, des_cipher, des_valid,
    output in_ready, out_valid, out_data, des_start, des_plain, des_key
  );
  modport master (
    output in_valid, in_data, out_ready, des_cipher, des_valid,
    input  in_ready, out_valid, out_data, des_start, des_plain, des_key
  );
endinterface

// File: rtl/des_cbc_ctrl.sv
// ECB/CBC block-mode controller around a DES core: accept block, launch core,
// wait (with watchdog) for the result, return ciphertext.
module des_cbc_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   key,
  input  logic [63:0]   iv,
  input  logic          iv_load,
  input  logic          mode,
  des_cbc_ctrl_if.slave bus,
  output logic          busy,
  output logic          timeout_err
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_OUTPUT} state_t;

  state_t        state, nxt;
  logic [63:0]   chain, out_q, plain_q, key_q;
  logic          mode_q;
  logic [CW-1:0] cnt;
  logic          terr;
  logic          accept;
  logic          wd_hit;
  logic [63:0]   chain_eff;

  // iv loaded in the accepting cycle chains into that same block
  assign chain_eff = iv_load ? iv : chain;
  assign wd_hit    = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    nxt           = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.des_start = 1'b0;
    busy          = 1'b1;
    accept        = 1'b0;
    case (state)
      S_IDLE: begin
        busy         = 1'b0;
        bus.in_ready = ~rst_n;
        accept       = bus.in_valid & ~rst_n;
        if (accept) nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        bus.des_start = 1'b1;
        nxt           = S_WAIT;
      end
      S_WAIT: begin
        if (bus.des_valid) nxt = S_OUTPUT;
        else if (wd_hit)   nxt = S_IDLE;
      end
      S_OUTPUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= S_IDLE;
      chain   <= '0;
      out_q   <= '0;
      plain_q <= '0;
      key_q   <= '0;
      mode_q  <= 1'b0;
      cnt     <= '0;
      terr    <= 1'b0;
    end else begin
      state <= nxt;
      case (state)
        S_IDLE: begin
          if (iv_load) begin
            chain <= iv;
            terr  <= 1'b0;
          end
          if (accept) begin
            plain_q <= bus.in_data ^ (mode ? chain_eff : 64'd0);
            key_q   <= key;
            mode_q  <= mode;
          end
        end
        S_LAUNCH: cnt <= '0;
        S_WAIT: begin
          if (bus.des_valid) begin
            out_q <= bus.des_cipher;
            if (mode_q) chain <= bus.des_cipher;
          end else if (wd_hit) begin
            terr <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_data  = out_q;
  assign bus.des_plain = plain_q;
  assign bus.des_key   = key_q;
  assign timeout_err   = terr;
endmodule

// File: tb/tb_des_cbc_ctrl.sv
// Directed bench for des_cbc_ctrl with a fixed-latency DES core stand-in.
module tb_des_cbc_ctrl;
  localparam int L = 16;
  localparam logic [63:0] P   = 64'h0123456789ABCDEF;
  localparam logic [63:0] K   = 64'h133457799BBCDFF1;
  localparam logic [63:0] C1  = 64'h85E813540F0AB405;
  localparam logic [63:0] PX1 = 64'h84CB563386A179EA;  // P ^ C1
  localparam logic [63:0] D3  = 64'hFEDCBA9876543210;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] key, iv;
  logic        iv_load, mode;
  logic        busy, timeout_err;
  logic        iv_load2, busy2, terr2;
  logic        core_vld = 1'b0;
  logic        spur_vld;
  logic [63:0] cipher_r = '0;
  int          core_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  des_cbc_ctrl_if bus ();
  des_cbc_ctrl_if bus2 ();

  des_cbc_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .iv_load(iv_load), .mode(mode),
    .bus(bus.slave), .busy(busy), .timeout_err(timeout_err)
  );

  des_cbc_ctrl #(.TIMEOUT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .key(key), .iv(iv), .iv_load(iv_load2), .mode(mode),
    .bus(bus2.slave), .busy(busy2), .timeout_err(terr2)
  );

  assign bus.des_valid   = core_vld | spur_vld;
  assign bus.des_cipher  = cipher_r;
  assign bus2.des_valid  = 1'b0;
  assign bus2.des_cipher = '0;

  // Known DES vector, otherwise a cheap invertible scramble
  function automatic logic [63:0] core_f(input logic [63:0] p, input logic [63:0] k);
    if (p == P && k == K) return C1;
    return p ^ {k[31:0], k[63:32]} ^ 64'h5A5A_0F0F_3C3C_9696;
  endfunction

  // Core stand-in: result pulse L cycles into WAIT
  always @(negedge clk) begin
    core_vld = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_vld = 1'b1;
        cipher_r = core_f(bus.des_plain, bus.des_key);
      end
    end
    if (bus.des_start) core_cnt = L + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Accept one block; returns at the first out_valid cycle with lat = cycle index
  task automatic run_block(input logic [63:0] d, input logic m, input logic il,
                           input logic [63:0] ivv, input logic [63:0] exp_plain,
                           input bit spur, output int lat);
    int starts;
    @(negedge clk);
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    bus.in_data  = d;
    mode         = m;
    iv_load      = il;
    iv           = ivv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("launch_start", 64'(bus.des_start), 64'd1);
    chk("launch_plain", bus.des_plain, exp_plain);
    chk("launch_key", bus.des_key, key);
    starts = 0;
    lat    = 1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.des_start) starts++;
      spur_vld = spur && (lat == 1);
      iv_load  = spur && (lat == 2 || lat == 3);
      if (spur) iv = '1;
      @(negedge clk);
      lat++;
    end
    spur_vld = 1'b0;
    iv_load  = 1'b0;
    chk("start_pulses", 64'(starts), 64'd1);
    chk("plain_held", bus.des_plain, exp_plain);
  endtask

  task automatic finish_out(input logic [63:0] exp, input int hold);
    chk("out_data", bus.out_data, exp);
    if (hold > 0) begin
      bus.out_ready = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        chk("bp_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_data", bus.out_data, exp);
        chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_drop", 64'(bus.out_valid), 64'd0);
    chk("idle_ready", 64'(bus.in_ready), 64'd1);
    chk("idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] c2, c3, c5;
    int lat, waits, seen;
    rst_n = 1'b1;
    key = K; iv = '0; iv_load = 1'b0; mode = 1'b0; iv_load2 = 1'b0; spur_vld = 1'b0;
    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready_held", 64'(bus.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_start", 64'(bus.des_start), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_plain", bus.des_plain, 64'd0);
    chk("rst_key", bus.des_key, 64'd0);

    // ECB known vector
    run_block(P, 1'b0, 1'b0, 64'd0, P, 1'b0, lat);
    chk("ecb_latency", 64'(lat), 64'd19);
    finish_out(C1, 0);

    // watchdog on the TIMEOUT=8 instance
    @(negedge clk);
    bus2.in_data = P; bus2.in_valid = 1'b1;
    @(negedge clk);
    bus2.in_valid = 1'b0;
    chk("to_launch", 64'(bus2.des_start), 64'd1);
    waits = 0; seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy2 && !bus2.des_start) waits++;
      if (bus2.out_valid) seen++;
    end
    chk("to_wait_cycles", 64'(waits), 64'd8);
    chk("to_no_output", 64'(seen), 64'd0);
    chk("to_err_set", 64'(terr2), 64'd1);
    chk("to_idle_ready", 64'(bus2.in_ready), 64'd1);
    iv_load2 = 1'b1;
    @(negedge clk);
    iv_load2 = 1'b0;
    chk("to_err_clear", 64'(terr2), 64'd0);

    // CBC with iv loaded alongside the first block
    run_block(P, 1'b1, 1'b1, 64'd0, P, 1'b0, lat);
    finish_out(C1, 0);
    run_block(P, 1'b1, 1'b0, 64'd0, PX1, 1'b0, lat);
    c2 = core_f(PX1, K);
    finish_out(c2, 0);
    run_block(P, 1'b1, 1'b0, 64'd0, P ^ c2, 1'b0, lat);
    c3 = core_f(P ^ c2, K);
    finish_out(c3, 0);

    // backpressure on an ECB block (chain must stay c3)
    run_block(D3, 1'b0, 1'b0, 64'd0, D3, 1'b0, lat);
    finish_out(core_f(D3, K), 10);

    // spurious des_valid in IDLE, LAUNCH; iv_load during WAIT
    @(negedge clk);
    spur_vld = 1'b1;
    @(negedge clk);
    spur_vld = 1'b0;
    chk("spur_idle_busy", 64'(busy), 64'd0);
    chk("spur_idle_ov", 64'(bus.out_valid), 64'd0);
    run_block(~D3, 1'b0, 1'b0, 64'd0, ~D3, 1'b1, lat);
    chk("spur_latency", 64'(lat), 64'd19);
    finish_out(core_f(~D3, K), 0);
    run_block(P, 1'b1, 1'b0, 64'd0, P ^ c3, 1'b0, lat);
    c5 = core_f(P ^ c3, K);
    finish_out(c5, 0);

    // reset at WAIT cycle 5
    @(negedge clk);
    bus.in_data = P; mode = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_wait_busy", 64'(busy), 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_start", 64'(bus.des_start), 64'd0);
    chk("mrst_plain", bus.des_plain, 64'd0);
    chk("mrst_key", bus.des_key, 64'd0);
    chk("mrst_out_data", bus.out_data, 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid || busy) seen++;
    end
    chk("mrst_late_valid", 64'(seen), 64'd0);
    run_block(P, 1'b1, 1'b0, 64'd0, P, 1'b0, lat);
    finish_out(C1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
